// File: rtl/sr_dmem_ctrl.sv
// sr_dmem_ctrl: data-memory controller between the CPU data port and a
// single-port synchronous-read word RAM. Handles sub-word loads with
// extension, sub-word stores as read-modify-write, misalignment detection
// and fair arbitration between the CPU and a debug/loader port.
module sr_dmem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [31:0]       cpuAddr,
    input  logic [31:0]       cpuWData,
    input  logic              cpuByte,
    input  logic              cpuHalf,
    input  logic              cpuWord,
    input  logic              cpuSign,
    output logic [31:0]       cpuRData,
    output logic              cpuStall,
    output logic              cpuMisalign,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [31:0]       dbgWData,
    output logic              dbgAck,
    output logic [31:0]       dbgRData,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [31:0]       ramWData,
    output logic              ramWe,
    input  logic [31:0]       ramRData
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_MERGE = 2'd2;
    localparam logic [1:0] S_DBG   = 2'd3;

    // Byte/half extraction from a RAM word with sign or zero extension.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        is_byte,
        input logic        is_half,
        input logic        sign_ext
    );
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [31:0]        res;
        sb = word[7:0];
        case (lane)
            2'd1:    sb = word[15:8];
            2'd2:    sb = word[23:16];
            2'd3:    sb = word[31:24];
            default: sb = word[7:0];
        endcase
        sh = lane[1] ? word[31:16] : word[15:0];
        if (is_byte)
            res = sign_ext ? {{24{sb[7]}}, sb} : {24'd0, sb};
        else if (is_half)
            res = sign_ext ? {{16{sh[15]}}, sh} : {16'd0, sh};
        else
            res = word;
        return res;
    endfunction

    // Replace the addressed byte/half of a RAM word with new store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        is_byte,
        input logic [15:0] data
    );
        logic [31:0] res;
        res = word;
        if (is_byte) begin
            case (lane)
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                2'd3:    res[31:24] = data[7:0];
                default: res[7:0]   = data[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = data;
        end else begin
            res[15:0] = data;
        end
        return res;
    endfunction

    logic [1:0]        r_state;
    logic              r_dbg_last;
    logic [ADDR_W-1:0] r_addr_word;
    logic [1:0]        r_lane;
    logic              r_byte;
    logic              r_half;
    logic              r_sign;
    logic [15:0]       r_wdata;

    logic [1:0]        w_next_state;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_misalign;
    logic              w_cpu_valid;
    logic              w_dbg_wins;
    logic              w_cpu_wins;
    logic              w_grant_dbg;
    logic              w_grant_cpu;
    logic [ADDR_W-1:0] w_cpu_word;
    logic              w_unused;

    // Zero or multiple size bits fall back to a word access.
    assign w_is_byte   = cpuByte & ~cpuHalf & ~cpuWord;
    assign w_is_half   = cpuHalf & ~cpuByte & ~cpuWord;
    assign w_is_word   = ~(w_is_byte | w_is_half);
    assign w_misalign  = cpuReq & ((w_is_half & cpuAddr[0]) |
                                   (w_is_word & (cpuAddr[1:0] != 2'd0)));
    assign w_cpu_valid = cpuReq & ~w_misalign;
    assign w_cpu_word  = cpuAddr[ADDR_W+1:2];
    assign w_unused    = &{1'b0, cpuAddr[31:ADDR_W+2]};

    // Debug yields to a waiting CPU only if debug was granted last.
    assign w_dbg_wins  = dbgReq & (~w_cpu_valid | ~r_dbg_last);
    assign w_cpu_wins  = w_cpu_valid & ~w_dbg_wins;
    assign w_grant_dbg = (r_state == S_IDLE) & w_dbg_wins;
    assign w_grant_cpu = (r_state == S_IDLE) & w_cpu_wins;

    // Output decode and next-state; everything held at reset values while rst_n is low.
    always_comb begin
        cpuRData     = '0;
        dbgRData     = '0;
        cpuStall     = 1'b0;
        cpuMisalign  = 1'b0;
        dbgAck       = 1'b0;
        ramAddr      = '0;
        ramWData     = '0;
        ramWe        = 1'b0;
        w_next_state = r_state;
        if (rst_n) begin
            cpuMisalign = w_misalign;
            case (r_state)
                S_IDLE: begin
                    if (w_dbg_wins) begin
                        ramAddr      = dbgAddr;
                        ramWe        = dbgWe;
                        ramWData     = dbgWe ? dbgWData : 32'd0;
                        cpuStall     = w_cpu_valid;
                        w_next_state = S_DBG;
                    end else if (w_cpu_wins) begin
                        ramAddr = w_cpu_word;
                        if (cpuWe && w_is_word) begin
                            ramWe    = 1'b1;
                            ramWData = cpuWData;
                        end else begin
                            cpuStall     = 1'b1;
                            w_next_state = cpuWe ? S_MERGE : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    ramAddr      = r_addr_word;
                    cpuRData     = load_extract(ramRData, r_lane, r_byte, r_half, r_sign);
                    w_next_state = S_IDLE;
                end
                S_MERGE: begin
                    ramAddr      = r_addr_word;
                    ramWe        = 1'b1;
                    ramWData     = store_merge(ramRData, r_lane, r_byte, r_wdata);
                    w_next_state = S_IDLE;
                end
                default: begin
                    dbgAck       = 1'b1;
                    dbgRData     = ramRData;
                    cpuStall     = w_cpu_valid;
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Control state: FSM and fairness flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dbg_last <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_dbg)
                r_dbg_last <= 1'b1;
            else if (w_grant_cpu)
                r_dbg_last <= 1'b0;
        end
    end

    // Capture the CPU access so LOAD/MERGE do not depend on the held inputs.
    always_ff @(posedge clk) begin
        if (w_grant_cpu) begin
            r_addr_word <= w_cpu_word;
            r_lane      <= cpuAddr[1:0];
            r_byte      <= w_is_byte;
            r_half      <= w_is_half;
            r_sign      <= cpuSign;
            r_wdata     <= cpuWData[15:0];
        end
    end

endmodule

// File: tb/tb_sr_dmem_ctrl.sv
// Directed testbench for sr_dmem_ctrl with a behavioural synchronous-read RAM.
module tb_sr_dmem_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpuReq, cpuWe, cpuByte, cpuHalf, cpuWord, cpuSign;
    logic [31:0]       cpuAddr, cpuWData, cpuRData;
    logic              cpuStall, cpuMisalign;
    logic              dbgReq, dbgWe, dbgAck;
    logic [ADDR_W-1:0] dbgAddr;
    logic [31:0]       dbgWData, dbgRData;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       ramWData, ramRData;
    logic              ramWe;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    sr_dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuByte(cpuByte), .cpuHalf(cpuHalf), .cpuWord(cpuWord), .cpuSign(cpuSign),
        .cpuRData(cpuRData), .cpuStall(cpuStall), .cpuMisalign(cpuMisalign),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWData(dbgWData),
        .dbgAck(dbgAck), .dbgRData(dbgRData),
        .ramAddr(ramAddr), .ramWData(ramWData), .ramWe(ramWe), .ramRData(ramRData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramWe) mem[ramAddr] <= ramWData;
        ramRData <= mem[ramAddr];
    end

    task automatic cpu_set(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic b, input logic h,
                           input logic w, input logic s);
        cpuReq = req; cpuWe = we; cpuAddr = addr; cpuWData = wd;
        cpuByte = b; cpuHalf = h; cpuWord = w; cpuSign = s;
    endtask

    task automatic cpu_idle();
        cpu_set(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_idle();
        dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWData = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({cpuStall, cpuMisalign, dbgAck, ramWe} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {cpuStall, cpuMisalign, dbgAck, ramWe});
        end
        checks++;
        if ({cpuRData, dbgRData, ramWData} !== 96'd0 || ramAddr !== '0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want zeros", cpuRData, dbgRData, ramWData, ramAddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_dbg_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bit got;
        @(negedge clk);
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = a; dbgWData = d;
        #1;
        checks++;
        if (ramWe !== 1'b1 || ramAddr !== a || ramWData !== d) begin
            errors++; $display("FAIL dbg_wr_grant got we=%b a=%h d=%h want 1 %h %h", ramWe, ramAddr, ramWData, a, d);
        end
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk); #1;
            if (dbgAck === 1'b1) got = 1'b1;
        end
        dbgReq = 1'b0; dbgWe = 1'b0;
        checks++;
        if (!got || mem[a] !== d) begin
            errors++; $display("FAIL dbg_wr_ack got ack=%b mem=%h want 1 %h", got, mem[a], d);
        end
    endtask

    task automatic test_load(input logic sgn, input logic [31:0] exp);
        @(negedge clk);
        cpu_set(1'b1, 1'b0, 32'h06, 32'd0, 1'b1, 1'b0, 1'b0, sgn);
        #1;
        checks++;
        if (cpuStall !== 1'b1 || ramAddr !== 8'd1) begin
            errors++; $display("FAIL load_grant got stall=%b addr=%h want 1 01", cpuStall, ramAddr);
        end
        @(negedge clk); #1;
        checks++;
        if (cpuStall !== 1'b0 || cpuRData !== exp) begin
            errors++; $display("FAIL load_data got stall=%b rdata=%h want 0 %h", cpuStall, cpuRData, exp);
        end
        cpu_idle();
    endtask

    task automatic test_subword_store(input logic [31:0] addr, input logic [31:0] wd,
                                      input logic b, input logic [31:0] exp);
        @(negedge clk);
        cpu_set(1'b1, 1'b1, addr, wd, b, ~b, 1'b0, 1'b0);
        #1;
        checks++;
        if (cpuStall !== 1'b1 || ramWe !== 1'b0) begin
            errors++; $display("FAIL rmw_read got stall=%b we=%b want 1 0", cpuStall, ramWe);
        end
        @(negedge clk); #1;
        checks++;
        if (cpuStall !== 1'b0 || ramWe !== 1'b1 || ramWData !== exp) begin
            errors++; $display("FAIL rmw_write got stall=%b we=%b d=%h want 0 1 %h", cpuStall, ramWe, ramWData, exp);
        end
        cpu_idle();
        @(negedge clk); #1;
        checks++;
        if (mem[1] !== exp) begin
            errors++; $display("FAIL rmw_mem got %h want %h", mem[1], exp);
        end
    endtask

    task automatic test_word_store();
        @(negedge clk);
        cpu_set(1'b1, 1'b1, 32'h0C, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (cpuStall !== 1'b0 || ramWe !== 1'b1 || ramAddr !== 8'd3 || ramWData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_store got stall=%b we=%b a=%h d=%h want 0 1 03 deadbeef",
                               cpuStall, ramWe, ramAddr, ramWData);
        end
        @(negedge clk);
        cpu_idle();
        #1;
        checks++;
        if (mem[3] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_store_mem got %h want deadbeef", mem[3]);
        end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        cpu_set(1'b1, 1'b0, 32'h02, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (cpuMisalign !== 1'b1 || cpuStall !== 1'b0 || cpuRData !== 32'd0 || ramWe !== 1'b0) begin
            errors++; $display("FAIL misalign_word got mis=%b stall=%b rd=%h we=%b want 1 0 0 0",
                               cpuMisalign, cpuStall, cpuRData, ramWe);
        end
        @(negedge clk);
        cpu_set(1'b1, 1'b1, 32'h05, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (cpuMisalign !== 1'b1 || cpuStall !== 1'b0 || ramWe !== 1'b0) begin
            errors++; $display("FAIL misalign_half got mis=%b stall=%b we=%b want 1 0 0", cpuMisalign, cpuStall, ramWe);
        end
        @(negedge clk);
        cpu_idle();
        #1;
        checks++;
        if (mem[1] !== 32'h1234AA5A || cpuMisalign !== 1'b0) begin
            errors++; $display("FAIL misalign_mem got %h mis=%b want 1234aa5a 0", mem[1], cpuMisalign);
        end
    endtask

    task automatic test_back_to_back();
        logic        e_stall [0:7];
        logic        e_ack   [0:7];
        logic [31:0] e_crd   [0:7];
        logic [31:0] e_drd   [0:7];
        e_stall = '{1, 1, 1, 0, 1, 1, 1, 0};
        e_ack   = '{0, 1, 0, 0, 0, 1, 0, 0};
        e_crd   = '{0, 0, 0, 32'h1234AA5A, 0, 0, 0, 32'hDEADBEEF};
        e_drd   = '{0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cpu_set(1'b1, 1'b0, (k < 4) ? 32'h04 : 32'h0C, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 8'd3;
            #1;
            checks++;
            if (cpuStall !== e_stall[k] || dbgAck !== e_ack[k] ||
                cpuRData !== e_crd[k] || dbgRData !== e_drd[k]) begin
                errors++;
                $display("FAIL arb_cycle%0d got stall=%b ack=%b crd=%h drd=%h want %b %b %h %h",
                         k, cpuStall, dbgAck, cpuRData, dbgRData, e_stall[k], e_ack[k], e_crd[k], e_drd[k]);
            end
        end
        @(negedge clk);
        cpu_idle();
        dbgReq = 1'b0;
    endtask

    task automatic test_reset_merge();
        @(negedge clk);
        cpu_set(1'b1, 1'b1, 32'h08, 32'h000000EE, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (cpuStall !== 1'b1) begin
            errors++; $display("FAIL rstm_grant got stall=%b want 1", cpuStall);
        end
        @(negedge clk); #1;
        checks++;
        if (ramWe !== 1'b1 || ramWData !== 32'h112233EE) begin
            errors++; $display("FAIL rstm_merge got we=%b d=%h want 1 112233ee", ramWe, ramWData);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ramWe !== 1'b0 || cpuStall !== 1'b0) begin
            errors++; $display("FAIL rstm_async got we=%b stall=%b want 0 0", ramWe, cpuStall);
        end
        @(negedge clk); #1;
        checks++;
        if (cpuStall !== 1'b0 || mem[2] !== 32'h11223344) begin
            errors++; $display("FAIL rstm_held got stall=%b mem=%h want 0 11223344", cpuStall, mem[2]);
        end
        cpu_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_set(1'b1, 1'b0, 32'h08, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (cpuStall !== 1'b1) begin
            errors++; $display("FAIL rstm_idle got stall=%b want 1", cpuStall);
        end
        @(negedge clk); #1;
        checks++;
        if (cpuStall !== 1'b0 || cpuRData !== 32'h11223344) begin
            errors++; $display("FAIL rstm_reload got stall=%b rd=%h want 0 11223344", cpuStall, cpuRData);
        end
        cpu_idle();
    endtask

    initial begin
        test_reset();
        test_dbg_write(8'd1, 32'h8899AABB);
        test_dbg_write(8'd2, 32'h11223344);
        test_load(1'b1, 32'hFFFFFF99);
        test_load(1'b0, 32'h00000099);
        test_subword_store(32'h06, 32'h00001234, 1'b0, 32'h1234AABB);
        test_subword_store(32'h04, 32'h0000005A, 1'b1, 32'h1234AA5A);
        test_word_store();
        test_misalign();
        test_back_to_back();
        test_reset_merge();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_dmem_ctrl.md
# sr_dmem_ctrl

Data-memory controller between the single-cycle CPU data port and a single-port, synchronous-read word RAM. It sequences every CPU access:
- loads with byte/half/word extraction and sign/zero extension;
- sub-word stores as read-modify-write;
- misaligned-access detection.

It also arbitrates the RAM between the CPU and a debug/loader port, freezing the CPU through a stall line while the RAM is busy.

## Interface
- ADDR_W, 8, RAM word-address width (RAM depth 2^ADDR_W words)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpuReq  in  1  CPU data access valid this cycle (load or store)
- cpuWe  in  1  1 = store, 0 = load
- cpuAddr  in  32  byte address; word index = cpuAddr[ADDR_W+1:2], upper bits ignored
- cpuWData  in  32  store data, LSB-aligned
- cpuByte / cpuHalf / cpuWord  in  1 each  access size, one-hot; zero or multiple set → treated as word
- cpuSign  in  1  1 = sign-extend sub-word load, 0 = zero-extend
- cpuRData  out  32  load result, valid in the cycle cpuStall drops for a load
- cpuStall  out  1  CPU must hold all inputs and not commit
- cpuMisalign  out  1  current request is misaligned; access suppressed
- dbgReq  in  1  debug access request, level, held until dbgAck
- dbgWe  in  1  debug store (full word)
- dbgAddr  in  ADDR_W  debug word address
- dbgWData  in  32  debug store data
- dbgAck  out  1  one-cycle completion pulse
- dbgRData  out  32  debug read data, valid with dbgAck
- ramAddr  out  ADDR_W  RAM word address
- ramWData  out  32  RAM write data
- ramWe  out  1  RAM write enable
- ramRData  in  32  RAM read data, valid the cycle after the address edge

## Operation
- States:
  - IDLE
  - LOAD: wait for read data
  - MERGE: RMW write
  - DBG: debug completion
- Fairness flag dbgLast: set when a debug access is granted, cleared when a CPU access is granted.
- IDLE arbitration: when dbgReq and a valid aligned cpuReq coincide, debug wins if dbgLast=0, otherwise the CPU wins. A lone requester always wins.
- Misalignment:
  - half access with addr[0]=1, or word access with addr[1:0]≠0;
  - in IDLE: cpuMisalign=1, no RAM access, cpuStall=0, cpuRData=0;
  - does not take part in arbitration.
- CPU word store (IDLE grant): ramWe=1, ramWData=cpuWData, cpuStall=0, stay IDLE.
- CPU load (IDLE grant):
  - drive ramAddr, cpuStall=1 → LOAD.
  - In LOAD, extract a byte at lane addr[1:0] or a half at lane addr[1]; extend per cpuSign and drive cpuRData.
  - cpuStall=0 → IDLE.
- CPU sub-word store (IDLE grant):
  - read the word, cpuStall=1 → MERGE.
  - In MERGE, write ramRData with the addressed byte/half replaced by cpuWData[7:0]/[15:0]; ramWe=1, cpuStall=0 → IDLE.
- Debug grant (IDLE):
  - drive dbgAddr; if dbgWe, ramWe=1 with dbgWData; → DBG.
  - In DBG: dbgAck=1, dbgRData=ramRData (store: don't-care) → IDLE.
- CPU stall rule: cpuStall=1 whenever cpuReq is valid and aligned but not completing this cycle. This includes losing arbitration and DBG state.
- Defaults in every state: cpuRData=0 except in LOAD; dbgRData=0 except in DBG.
- LOAD/MERGE hold ramAddr from a captured address register.

## Timing
- Reset values:
  - state=IDLE, dbgLast=0;
  - cpuStall, cpuMisalign, dbgAck, ramWe = 0 (with no requests);
  - cpuRData, dbgRData, ramAddr, ramWData = 0.
- Latencies:
  - word store: 0 stall cycles;
  - load and sub-word store: 1 stall cycle;
  - debug access: ack 1 cycle after grant;
  - CPU loses 2 cycles to a colliding debug access.
- No access is ever interrupted once granted. dbgReq arriving in LOAD/MERGE waits for IDLE.
- dbgReq still high in the cycle after dbgAck is a new request; fairness then grants a waiting CPU first.
- Asynchronous reset mid-access: → IDLE immediately and outputs go to reset values. A MERGE write whose edge has not occurred is lost, and no partial RAM write is issued.
- Outputs are combinational from state + registered captures + inputs. No combinational path from ramRData exists outside LOAD/MERGE/DBG.

## Test plan
- RAM[1]=0x8899AABB; load byte, cpuSign=1, addr 0x06 → cpuStall high 1 cycle, then cpuRData=0xFFFFFF99. Same with cpuSign=0 → 0x00000099.
- Store half 0x1234 to addr 0x06 over RAM[1]=0x8899AABB → 1 stall cycle, RAM[1]=0x1234AABB. Store byte 0x5A to addr 0x04 → RAM[1]=0x1234AA5A.
- Word store 0xDEADBEEF to addr 0x0C → ramWe same cycle, cpuStall never high, RAM[3]=0xDEADBEEF.
- Misaligned word load at addr 0x02 and half store at 0x05 → cpuMisalign=1, cpuStall=0, cpuRData=0, RAM unchanged.
- dbgReq held with back-to-back CPU loads → grants alternate debug/CPU; dbgAck pulses 1 cycle; dbgRData matches RAM; no starvation either side.
- rst_n low during MERGE of a byte store → state IDLE, RAM word unchanged, cpuStall=0 while reset held.
